// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
//
// Sole driver of an HD44780 16x2 character LCD bus (8-bit, write-only).
// After reset it waits out the LCD power-up time, plays a fixed four-byte
// init sequence (0x38, 0x0E, 0x01, 0x06, all commands), then shares the LCD
// between two byte-level requesters using round-robin arbitration.
//
// Every byte goes through the same timing:
//   SETUP : lcd_rs/lcd_data stable, lcd_en low   (SETUP_CYC cycles)
//   PULSE : lcd_en high                           (EN_CYC cycles)
//   WAIT  : lcd_en low, LCD executes the command  (LONG_WAIT_CYC for
//           clear/home, SHORT_WAIT_CYC otherwise)
//
// Handshake (both requesters): a byte moves on a rising clk edge where
// reqK_valid && reqK_ready. A requester holds valid/rs/data stable until that
// edge and never derives valid from ready. ready is combinational from the
// valids, the FSM state and the last-grant pointer; it is high only in IDLE,
// only after init, and for at most one requester at a time.
//
// Build option:
//   LCD_FIXED_PRIO_EN : when defined, req0 always wins a tie; the last-grant
//                       pointer still updates but is not used for selection.
//                       When undefined, ties alternate (round-robin).
//
// Ports:
//   clk, rst_n               50 MHz clock, asynchronous active-low reset
//   req0_valid/rs/data/ready requester 0 byte channel (CPU result display)
//   req1_valid/rs/data/ready requester 1 byte channel (status/messages)
//   lcd_en, lcd_rw, lcd_rs, lcd_data   LCD pins (lcd_rw tied 0)
//   init_done                high once the init sequence has completed
//   busy                     high in every state except IDLE
//   grant_id                 requester of the last accepted byte
//   dbg_state                current FSM state (lcd_state_e encoding)
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_CYC         = 25,
  parameter int unsigned SHORT_WAIT_CYC = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 82000,
  parameter int unsigned PWRUP_CYC      = 750000
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,

  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,

  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,

  output logic       init_done,
  output logic       busy,
  output logic       grant_id,
  output logic [2:0] dbg_state
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_IDLE  = 3'd4
  } lcd_state_e;

  // Each timed state counts 0 .. LAST and leaves on the cycle the counter
  // equals LAST, so the state occupies exactly N cycles.
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC)      - 32'd1;
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC)      - 32'd1;
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC)         - 32'd1;
  localparam logic [31:0] SHORT_LAST = 32'(SHORT_WAIT_CYC) - 32'd1;
  localparam logic [31:0] LONG_LAST  = 32'(LONG_WAIT_CYC)  - 32'd1;

  localparam logic [1:0] INIT_LAST_IDX = 2'd3;

  // Fixed HD44780 init sequence: 8-bit/2-line/5x8, display on + cursor,
  // clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0E;
      2'd2:    b = 8'h01;
      2'd3:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // -------------------------------------------------------------------------
  // Flops
  // -------------------------------------------------------------------------
  lcd_state_e state_q,      state_d;
  logic [31:0] cnt_q,       cnt_d;
  logic [1:0]  init_idx_q,  init_idx_d;
  logic        lcd_en_q,    lcd_en_d;
  logic        lcd_rs_q,    lcd_rs_d;
  logic [7:0]  lcd_data_q,  lcd_data_d;
  logic        init_done_q, init_done_d;
  logic        busy_q,      busy_d;
  logic        grant_id_q,  grant_id_d;
  logic        last_grant_q, last_grant_d;

  // -------------------------------------------------------------------------
  // Arbitration (combinational)
  // -------------------------------------------------------------------------
  logic sel;        // requester picked this cycle
  logic arb_open;   // a byte may be accepted this cycle
  logic accept;     // the selected requester's byte moves on this edge
  logic sel_rs;
  logic [7:0] sel_data;

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef LCD_FIXED_PRIO_EN
      sel = 1'b0;
`else
      // Tie: give the bus to whoever did not get it last time.
      sel = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
  end

  assign arb_open   = (state_q == ST_IDLE) && init_done_q;
  assign req0_ready = arb_open && req0_valid && (sel == 1'b0);
  assign req1_ready = arb_open && req1_valid && (sel == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign sel_rs   = sel ? req1_rs   : req0_rs;
  assign sel_data = sel ? req1_data : req0_data;

  // -------------------------------------------------------------------------
  // Post-pulse wait length: clear display (0x01) and return home (0x02/0x03)
  // take far longer inside the LCD than every other command or character.
  // The byte in lcd_data_q is the one just strobed, so it decides the wait.
  // -------------------------------------------------------------------------
  logic        long_wait;
  logic [31:0] wait_last;

  assign long_wait = !lcd_rs_q &&
                     ((lcd_data_q[7:1] == 7'b0000000) ||
                      (lcd_data_q[7:1] == 7'b0000001));
  assign wait_last = long_wait ? LONG_LAST : SHORT_LAST;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    init_idx_d   = init_idx_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    init_done_d  = init_done_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d    = ST_SETUP;
          cnt_d      = 32'd0;
          init_idx_d = 2'd0;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_byte(2'd0);
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = 32'd0;
        end
      end

      ST_PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = 32'd0;
        end
      end

      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = 32'd0;
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (init_idx_q == INIT_LAST_IDX) begin
            // Last init byte has settled: the LCD is ready for traffic.
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_byte(init_idx_q + 2'd1);
            state_d    = ST_SETUP;
          end
        end
      end

      ST_IDLE: begin
        // IDLE is untimed; keep the counter parked so it cannot wrap.
        cnt_d = 32'd0;
        if (accept) begin
          state_d      = ST_SETUP;
          lcd_rs_d     = sel_rs;
          lcd_data_d   = sel_data;
          grant_id_d   = sel;
          last_grant_d = sel;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        cnt_d   = 32'd0;
      end
    endcase

    // Registered from the next state so lcd_en/busy change cleanly on the
    // clock edge and line up exactly with the state they describe.
    lcd_en_d = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers. Reset aborts any transfer at once: lcd_en drops
  // asynchronously and the block restarts from power-up.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PWRUP;
      cnt_q        <= 32'd0;
      init_idx_q   <= 2'd0;
      lcd_en_q     <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      lcd_en_q     <= lcd_en_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign lcd_en    = lcd_en_q;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//
// Directed bench for lcd_bus_arbiter with shrunk timing
// (SETUP=2, EN=4, SHORT=10, LONG=40, PWRUP=50). Outputs are sampled 1 time
// unit after each rising clk edge; inputs are driven at the same point.
// Build with +define+LCD_FIXED_PRIO_EN to check the fixed-priority variant.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int SHORT = 10;
  localparam int LONG  = 40;
  localparam int PWRUP = 50;
  localparam int LIMIT = 2000;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       lcd_en, lcd_rw, lcd_rs;
  logic [7:0] lcd_data;
  logic       init_done, busy, grant_id;
  logic [2:0] dbg_state;

  lcd_bus_arbiter #(
    .SETUP_CYC      (SETUP),
    .EN_CYC         (EN),
    .SHORT_WAIT_CYC (SHORT),
    .LONG_WAIT_CYC  (LONG),
    .PWRUP_CYC      (PWRUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_en     (lcd_en),
    .lcd_rw     (lcd_rw),
    .lcd_rs     (lcd_rs),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .dbg_state  (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int early_ready = 0;          // samples with a ready high before init_done
  logic [7:0] exp_q[$];         // expected init bytes, in order

  // -------------------------------------------------------------------------
  // Driver / checker tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if ((req0_ready || req1_ready) && !init_done) early_ready++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count samples while lcd_en stays at lvl (bounded).
  task automatic count_en(input logic lvl, output int n);
    n = 0;
    while (lcd_en === lvl && n < LIMIT) begin
      n++;
      tick();
    end
  endtask

  // Called on the sample right after reset release (or with rst_n just
  // released). Checks the whole power-up + init sequence timing.
  task automatic check_init(input string pfx);
    int n;
    int lows [4];
    logic [7:0] exp_b;
    lows = '{PWRUP + SETUP, SHORT + SETUP, SHORT + SETUP, LONG + SETUP};
    exp_q = {8'h38, 8'h0E, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++) begin
      count_en(1'b0, n);
      chk($sformatf("%s_low%0d", pfx, i), n, lows[i]);
      exp_b = exp_q.pop_front();
      chk($sformatf("%s_data%0d", pfx, i), lcd_data, exp_b);
      chk($sformatf("%s_rs%0d", pfx, i), lcd_rs, 1'b0);
      count_en(1'b1, n);
      chk($sformatf("%s_en%0d", pfx, i), n, EN);
    end
    n = 0;
    while (!init_done && n < LIMIT) begin
      n++;
      tick();
    end
    chk({pfx, "_last_wait"}, n, SHORT);
    chk({pfx, "_init_done"}, init_done, 1'b1);
    chk({pfx, "_busy_idle"}, busy, 1'b0);
    chk({pfx, "_early_ready"}, early_ready, 0);
  endtask

  // Called on the sample right after the accepting edge.
  task automatic run_byte(input string tag, input logic rs, input logic [7:0] data,
                          input logic gid, input int wait_exp);
    int n;
    chk({tag, "_rs"}, lcd_rs, rs);
    chk({tag, "_data"}, lcd_data, data);
    chk({tag, "_gid"}, grant_id, gid);
    chk({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (lcd_en === 1'b0 && busy === 1'b1 && n < LIMIT) begin
      n++;
      tick();
    end
    chk({tag, "_setup"}, n, SETUP);
    count_en(1'b1, n);
    chk({tag, "_en"}, n, EN);
    n = 0;
    while (lcd_en === 1'b0 && busy === 1'b1 && n < LIMIT) begin
      n++;
      tick();
    end
    chk({tag, "_wait"}, n, wait_exp);
    chk({tag, "_hold"}, lcd_data, data);
  endtask

  // Single requester sends one byte starting on an IDLE sample.
  task automatic send(input string tag, input logic who, input logic rs,
                      input logic [7:0] data, input int wait_exp);
    if (!who) begin
      req0_valid = 1'b1; req0_rs = rs; req0_data = data;
    end else begin
      req1_valid = 1'b1; req1_rs = rs; req1_data = data;
    end
    #1;
    chk({tag, "_ready_sel"},   who ? req1_ready : req0_ready, 1'b1);
    chk({tag, "_ready_other"}, who ? req0_ready : req1_ready, 1'b0);
    tick();
    chk({tag, "_ready_drop"}, who ? req1_ready : req0_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_byte(tag, rs, data, who, wait_exp);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  logic exp_g [4];
  int   n;

  initial begin
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
`ifdef LCD_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    // last grant is req0 when this phase starts, so req1 goes first
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_en",    lcd_en,    1'b0);
    chk("rst_rw",    lcd_rw,    1'b0);
    chk("rst_rs",    lcd_rs,    1'b0);
    chk("rst_data",  lcd_data,  8'h00);
    chk("rst_init",  init_done, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_gid",   grant_id,  1'b0);
    chk("rst_state", dbg_state, 3'd0);

    // Power-up and init with no requests
    rst_n = 1'b1;
    check_init("init1");

    // Neither valid in IDLE: no ready
    chk("idle_r0", req0_ready, 1'b0);
    chk("idle_r1", req1_ready, 1'b0);
    chk("idle_state", dbg_state, 3'd4);

    // Single character from req0
    send("b41", 1'b0, 1'b1, 8'h41, SHORT);

    // Both valid continuously
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_r0", i), req0_ready, exp_g[i] == 1'b0);
      chk($sformatf("rr%0d_r1", i), req1_ready, exp_g[i] == 1'b1);
      tick();
      chk($sformatf("rr%0d_gid", i), grant_id, exp_g[i]);
      chk($sformatf("rr%0d_data", i), lcd_data, exp_g[i] ? 8'h31 : 8'h30);
      n = 0;
      while (busy === 1'b1 && n < LIMIT) begin
        n++;
        tick();
      end
      chk($sformatf("rr%0d_len", i), n, SETUP + EN + SHORT);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Return-home gets the long wait, DDRAM address gets the short one
    send("b02", 1'b1, 1'b0, 8'h02, LONG);
    send("bc0", 1'b1, 1'b0, 8'hC0, SHORT);
    repeat (3) tick();
    chk("idle_hold_data", lcd_data, 8'hC0);
    chk("idle_hold_rs",   lcd_rs,   1'b0);

    // Reset in the middle of an EN pulse
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (lcd_en !== 1'b1 && n < LIMIT) begin
      n++;
      tick();
    end
    tick();
    chk("mid_pulse_en", lcd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_en",   lcd_en,    1'b0);
    chk("abort_init", init_done, 1'b0);
    chk("abort_busy", busy,      1'b0);
    chk("abort_data", lcd_data,  8'h00);

    // req0 holds a byte through the whole power-up/init replay
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h48;
    tick();
    tick();
    rst_n = 1'b1;
    early_ready = 0;
    check_init("init2");
    chk("first_idle_ready", req0_ready, 1'b1);
    tick();
    chk("first_idle_drop", req0_ready, 1'b0);
    req0_valid = 1'b0;
    run_byte("b48", 1'b1, 8'h48, 1'b0, SHORT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
